// File: rtl/pe_pending_encoder.sv
// N-input priority encoder: latches request pulses into a pending vector and grants one per accept.
// Latency: a request seen at edge t is presented on y/v after that edge (one cycle), one grant per cycle.
// Backpressure: while v && !rdy, y/v hold and new requests keep accumulating in pend. Option: PE_ROUND_ROBIN_EN.
module pe_pending_encoder #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         a,
  input  logic                 rdy,
  output logic [$clog2(N)-1:0] y,
  output logic                 v,
  output logic [N-1:0]         pend,
  output logic                 ovf
);

  localparam int W = $clog2(N);

  logic         acc;
  logic         load;
  logic [N-1:0] clr;
  logic [N-1:0] pend_n;
  logic [W-1:0] enc;

  // Accept handshake, clear mask for the granted bit and next pending vector (set wins over clear)
  always_comb begin
    acc    = v && rdy;
    clr    = acc ? (N'(1) << y) : '0;
    pend_n = (pend & ~clr) | a;
    load   = !v || rdy;
  end

`ifdef PE_ROUND_ROBIN_EN
  logic [W-1:0] last;
  logic [W-1:0] last_eff;

  // Rotating priority: highest pending index below last wins, else highest index at or above last.
  // The pointer used is the one that will be in effect after this edge, so a granted source drops to lowest priority immediately.
  always_comb begin
    last_eff = acc ? y : last;
    enc      = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_n[i]) enc = W'(i);
    end
    for (int i = 0; i < N; i++) begin
      if (pend_n[i] && (W'(i) < last_eff)) enc = W'(i);
    end
  end

  // Pointer remembers the last accepted index; holds on stall or idle
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= '0;
    end else if (acc) begin
      last <= y;
    end
  end
`else
  // Fixed priority: highest pending index wins
  always_comb begin
    enc = '0;
    for (int i = 0; i < N; i++) begin
      if (pend_n[i]) enc = W'(i);
    end
  end
`endif

  // Pending/status state and registered output; output reloads whenever it is empty or being consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      y    <= '0;
      v    <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      pend <= pend_n;
      ovf  <= |(a & pend & ~clr);
      if (load) begin
        y <= enc;
        v <= |pend_n;
      end
    end
  end

endmodule
